// File: rtl/secret_accum_bank.sv
// secret_accum_bank
//   CHANNELS independent WIDTH-bit accumulators. Each accepted input adds
//   in_data plus the hidden constant SECRET_VALUE to the selected channel,
//   and the update is reported on a 1-entry registered valid/ready stream.
//   A combinational read/bypass port exposes either in_data or acc[rd_chan].
//
//   Optional build macro: SECRET_ACCUM_SAT_EN
//     defined   -> saturating accumulate (overflow stores all-ones)
//     undefined -> modular wrap; out_ovf still flags the carry
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clk_en              0 freezes all state (reset still applies)
//   in_valid/in_ready   input handshake; in_chan selects, in_data is addend
//   clr_valid/clr_chan  clear request (no handshake, no report)
//   out_valid/out_ready update report; out_chan/out_data/out_ovf payload
//   rd_chan/rd_bypass   combinational read select; rd_data result
//   accept_count        count of accepted in-range inputs (wraps at 2^32)
module secret_accum_bank #(
  parameter int WIDTH        = 32,
  parameter int CHANNELS     = 4,
  parameter int SECRET_VALUE = 7,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_chan,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_valid,
  input  logic [CW-1:0]    clr_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic [CW-1:0]    rd_chan,
  input  logic             rd_bypass,
  output logic [WIDTH-1:0] rd_data,
  output logic [31:0]      accept_count
);

  localparam logic [CW:0]      NCH      = (CW+1)'(CHANNELS);
  localparam logic [WIDTH+1:0] SECRET_X = {2'b00, WIDTH'(SECRET_VALUE)};

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic             out_valid_q;
  logic [CW-1:0]    out_chan_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;
  logic [31:0]      accept_count_q;

  logic             in_ready_w;
  logic             accept_w;
  logic             in_hit_w;
  logic             clr_hit_w;
  logic             ovf_d;
  logic [WIDTH-1:0] base_w;
  logic [WIDTH+1:0] sum_w;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] rd_sel_w;

  // Single-entry output register without skid: accept only when the slot
  // is empty or being drained this cycle.
  assign in_ready_w = clk_en & (~out_valid_q | out_ready);
  assign accept_w   = in_valid & in_ready_w;
  assign in_hit_w   = accept_w & ({1'b0, in_chan} < NCH);
  assign clr_hit_w  = clr_valid & clk_en & ({1'b0, clr_chan} < NCH);

  always_comb begin
    base_w = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (in_chan == CW'(c)) base_w = acc_q[c];
    end
    // Clear and add on the same channel: the add starts from zero.
    if (clr_valid && (clr_chan == in_chan)) base_w = '0;
    sum_w = {2'b00, base_w} + {2'b00, in_data} + SECRET_X;
    ovf_d = |sum_w[WIDTH+1:WIDTH];
`ifdef SECRET_ACCUM_SAT_EN
    acc_d = ovf_d ? '1 : sum_w[WIDTH-1:0];
`else
    acc_d = sum_w[WIDTH-1:0];
`endif
  end

  always_comb begin
    rd_sel_w = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rd_chan == CW'(c)) rd_sel_w = acc_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      out_valid_q    <= 1'b0;
      out_chan_q     <= '0;
      out_data_q     <= '0;
      out_ovf_q      <= 1'b0;
      accept_count_q <= '0;
    end else if (clk_en) begin
      // The accept write already accounts for a same-channel clear via
      // base_w, so it takes priority over the plain clear.
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (in_hit_w && (in_chan == CW'(c))) begin
          acc_q[c] <= acc_d;
        end else if (clr_hit_w && (clr_chan == CW'(c))) begin
          acc_q[c] <= '0;
        end
      end
      if (in_hit_w) begin
        out_valid_q    <= 1'b1;
        out_chan_q     <= in_chan;
        out_data_q     <= acc_d;
        out_ovf_q      <= ovf_d;
        accept_count_q <= accept_count_q + 32'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready     = in_ready_w;
  assign out_valid    = out_valid_q;
  assign out_chan     = out_chan_q;
  assign out_data     = out_data_q;
  assign out_ovf      = out_ovf_q;
  assign accept_count = accept_count_q;
  assign rd_data      = rd_bypass ? in_data : rd_sel_w;

endmodule

// File: tb/tb_secret_accum_bank.sv
// Testbench for secret_accum_bank.
//   u_main : WIDTH=32, CHANNELS=4 -- table of cycle vectors
//   u_small: WIDTH=8,  CHANNELS=3 -- wrap/out-of-range sequences and
//            randomized traffic against a reference model
module tb_secret_accum_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // main instance signals
  logic        m_rst_n, m_clk_en, m_in_valid, m_in_ready, m_clr_valid;
  logic        m_out_valid, m_out_ready, m_out_ovf, m_rd_bypass;
  logic [1:0]  m_in_chan, m_clr_chan, m_out_chan, m_rd_chan;
  logic [31:0] m_in_data, m_out_data, m_rd_data, m_accept_count;

  // small instance signals
  logic        s_rst_n, s_clk_en, s_in_valid, s_in_ready, s_clr_valid;
  logic        s_out_valid, s_out_ready, s_out_ovf, s_rd_bypass;
  logic [1:0]  s_in_chan, s_clr_chan, s_out_chan, s_rd_chan;
  logic [7:0]  s_in_data, s_out_data, s_rd_data;
  logic [31:0] s_accept_count;

  secret_accum_bank #(.WIDTH(32), .CHANNELS(4), .SECRET_VALUE(7)) u_main (
    .clk(clk), .rst_n(m_rst_n), .clk_en(m_clk_en),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_chan(m_in_chan), .in_data(m_in_data),
    .clr_valid(m_clr_valid), .clr_chan(m_clr_chan),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_chan(m_out_chan),
    .out_data(m_out_data), .out_ovf(m_out_ovf),
    .rd_chan(m_rd_chan), .rd_bypass(m_rd_bypass), .rd_data(m_rd_data),
    .accept_count(m_accept_count)
  );

  secret_accum_bank #(.WIDTH(8), .CHANNELS(3), .SECRET_VALUE(7)) u_small (
    .clk(clk), .rst_n(s_rst_n), .clk_en(s_clk_en),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_chan(s_in_chan), .in_data(s_in_data),
    .clr_valid(s_clr_valid), .clr_chan(s_clr_chan),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_chan(s_out_chan),
    .out_data(s_out_data), .out_ovf(s_out_ovf),
    .rd_chan(s_rd_chan), .rd_bypass(s_rd_bypass), .rd_data(s_rd_data),
    .accept_count(s_accept_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned rst_n, clk_en, in_valid, in_chan, in_data;
    int unsigned clr_valid, clr_chan, out_ready, rd_chan, rd_bypass;
    int unsigned e_in_ready, e_rd_data;
    int unsigned e_out_valid, e_out_chan, e_out_data, e_out_ovf, e_cnt;
  } vec_t;

  vec_t        vecs[$];
  vec_t        v;
  int unsigned ovd;
  int unsigned s_wrap;

  // reference model state for u_small
  int unsigned macc[3];
  int unsigned nxt[3];
  int unsigned mov, mchan, mdata, movf, mcnt, total, took, exp_rdy, exp_rd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef SECRET_ACCUM_SAT_EN
    ovd    = 32'hFFFF_FFFF;
    s_wrap = 255;
`else
    ovd    = 1;
    s_wrap = 1;
`endif
    //            rst en iv ch data        cv cc ordy rc byp | rdy rd         | ov oc odata oovf cnt
    vecs.push_back('{0, 1, 0, 0, 0,          0, 0, 1,  0, 0,   1, 0,            0, 0, 0,   0, 0});
    vecs.push_back('{1, 1, 1, 0, 5,          0, 0, 1,  0, 0,   1, 0,            1, 0, 12,  0, 1});
    vecs.push_back('{1, 1, 1, 0, 5,          0, 0, 1,  0, 0,   1, 12,           1, 0, 24,  0, 2});
    vecs.push_back('{1, 1, 1, 1, 1,          0, 0, 1,  0, 0,   1, 24,           1, 1, 8,   0, 3});
    vecs.push_back('{1, 1, 1, 1, 2,          0, 0, 0,  1, 0,   0, 8,            1, 1, 8,   0, 3});
    vecs.push_back('{1, 1, 1, 1, 2,          0, 0, 0,  1, 0,   0, 8,            1, 1, 8,   0, 3});
    vecs.push_back('{1, 1, 1, 1, 2,          0, 0, 1,  1, 0,   1, 8,            1, 1, 17,  0, 4});
    vecs.push_back('{1, 1, 0, 0, 'hDEAD,     0, 0, 1,  0, 1,   1, 'hDEAD,       0, 1, 17,  0, 4});
    vecs.push_back('{1, 1, 1, 2, 93,         0, 0, 1,  2, 0,   1, 0,            1, 2, 100, 0, 5});
    vecs.push_back('{1, 1, 1, 2, 3,          1, 2, 1,  2, 0,   1, 100,          1, 2, 10,  0, 6});
    vecs.push_back('{1, 1, 1, 3, 50,         1, 1, 1,  1, 0,   1, 17,           1, 3, 57,  0, 7});
    vecs.push_back('{1, 1, 0, 0, 0,          1, 3, 1,  1, 0,   1, 0,            0, 3, 57,  0, 7});
    vecs.push_back('{1, 1, 0, 0, 0,          0, 0, 1,  3, 0,   1, 0,            0, 3, 57,  0, 7});
    vecs.push_back('{1, 0, 1, 0, 9,          1, 0, 1,  0, 0,   0, 24,           0, 3, 57,  0, 7});
    vecs.push_back('{1, 0, 0, 0, 0,          0, 0, 1,  2, 0,   0, 10,           0, 3, 57,  0, 7});
    vecs.push_back('{0, 0, 1, 0, 9,          0, 0, 1,  0, 0,   0, 24,           0, 0, 0,   0, 0});
    vecs.push_back('{1, 1, 0, 0, 0,          0, 0, 1,  0, 0,   1, 0,            0, 0, 0,   0, 0});
    vecs.push_back('{1, 1, 1, 0, 1,          0, 0, 0,  0, 0,   1, 0,            1, 0, 8,   0, 1});
    vecs.push_back('{0, 1, 0, 0, 0,          0, 0, 0,  0, 0,   0, 8,            0, 0, 0,   0, 0});
    vecs.push_back('{1, 1, 1, 1, 'hFFFFFFFA, 0, 0, 1,  1, 0,   1, 0,            1, 1, ovd, 1, 1});
    vecs.push_back('{1, 1, 0, 0, 0,          0, 0, 1,  1, 0,   1, ovd,          0, 1, ovd, 1, 1});

    // initial reset of both instances
    m_rst_n = 1'b0; m_clk_en = 1'b1; m_in_valid = 1'b0; m_in_chan = '0; m_in_data = '0;
    m_clr_valid = 1'b0; m_clr_chan = '0; m_out_ready = 1'b1; m_rd_chan = '0; m_rd_bypass = 1'b0;
    s_rst_n = 1'b0; s_clk_en = 1'b1; s_in_valid = 1'b0; s_in_chan = '0; s_in_data = '0;
    s_clr_valid = 1'b0; s_clr_chan = '0; s_out_ready = 1'b1; s_rd_chan = '0; s_rd_bypass = 1'b0;
    @(posedge clk); #1;

    // ---- table-driven vectors on u_main ----
    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      m_rst_n     = 1'(v.rst_n);
      m_clk_en    = 1'(v.clk_en);
      m_in_valid  = 1'(v.in_valid);
      m_in_chan   = 2'(v.in_chan);
      m_in_data   = v.in_data;
      m_clr_valid = 1'(v.clr_valid);
      m_clr_chan  = 2'(v.clr_chan);
      m_out_ready = 1'(v.out_ready);
      m_rd_chan   = 2'(v.rd_chan);
      m_rd_bypass = 1'(v.rd_bypass);
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(m_in_ready), 64'(v.e_in_ready));
      chk($sformatf("v%0d rd_data", i), 64'(m_rd_data), 64'(v.e_rd_data));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 64'(m_out_valid), 64'(v.e_out_valid));
      chk($sformatf("v%0d out_chan", i), 64'(m_out_chan), 64'(v.e_out_chan));
      chk($sformatf("v%0d out_data", i), 64'(m_out_data), 64'(v.e_out_data));
      chk($sformatf("v%0d out_ovf", i), 64'(m_out_ovf), 64'(v.e_out_ovf));
      chk($sformatf("v%0d accept_count", i), 64'(m_accept_count), 64'(v.e_cnt));
    end

    // ---- hand sequence on u_small: 8-bit wrap, out-of-range channel ----
    @(negedge clk);
    s_rst_n = 1'b1; s_in_valid = 1'b1; s_in_chan = 2'd0; s_in_data = 8'd250; s_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("s_wrap out_valid", 64'(s_out_valid), 64'd1);
    chk("s_wrap out_data", 64'(s_out_data), 64'(s_wrap));
    chk("s_wrap out_ovf", 64'(s_out_ovf), 64'd1);
    chk("s_wrap accept_count", 64'(s_accept_count), 64'd1);
    @(negedge clk);
    s_in_chan = 2'd3; s_in_data = 8'd9; s_clr_valid = 1'b1; s_clr_chan = 2'd3;
    #1;
    chk("s_oor in_ready", 64'(s_in_ready), 64'd1);
    @(posedge clk); #1;
    chk("s_oor out_valid", 64'(s_out_valid), 64'd0);
    chk("s_oor accept_count", 64'(s_accept_count), 64'd1);
    @(negedge clk);
    s_in_valid = 1'b0; s_clr_valid = 1'b0; s_rd_chan = 2'd0;
    #1;
    chk("s_oor acc0 kept", 64'(s_rd_data), 64'(s_wrap));
    s_rd_chan = 2'd3;
    #1;
    chk("s_oor rd_chan3", 64'(s_rd_data), 64'd0);
    s_rst_n = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) macc[c] = 0;
    mov = 0; mchan = 0; mdata = 0; movf = 0; mcnt = 0;

    // ---- randomized traffic on u_small vs reference model ----
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      s_rst_n     = ($urandom_range(0, 99) != 0);
      s_clk_en    = ($urandom_range(0, 9) != 0);
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_in_chan   = 2'($urandom_range(0, 3));
      s_in_data   = 8'($urandom);
      s_clr_valid = ($urandom_range(0, 5) == 0);
      s_clr_chan  = 2'($urandom_range(0, 3));
      s_out_ready = ($urandom_range(0, 2) != 0);
      s_rd_chan   = 2'($urandom_range(0, 3));
      s_rd_bypass = ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = (s_clk_en && (mov == 0 || s_out_ready)) ? 1 : 0;
      if (s_rd_bypass) exp_rd = s_in_data;
      else if (s_rd_chan < 3) exp_rd = macc[s_rd_chan];
      else exp_rd = 0;
      chk($sformatf("r%0d in_ready", k), 64'(s_in_ready), 64'(exp_rdy));
      chk($sformatf("r%0d rd_data", k), 64'(s_rd_data), 64'(exp_rd));

      if (!s_rst_n) begin
        for (int c = 0; c < 3; c++) macc[c] = 0;
        mov = 0; mchan = 0; mdata = 0; movf = 0; mcnt = 0;
      end else if (s_clk_en) begin
        nxt  = macc;
        took = (s_in_valid && exp_rdy != 0) ? 1 : 0;
        if (s_clr_valid && s_clr_chan < 3) nxt[s_clr_chan] = 0;
        if (took != 0 && s_in_chan < 3) begin
          total = nxt[s_in_chan] + s_in_data + 7;
          movf  = (total > 255) ? 1 : 0;
`ifdef SECRET_ACCUM_SAT_EN
          mdata = (movf != 0) ? 255 : total;
`else
          mdata = total % 256;
`endif
          nxt[s_in_chan] = mdata;
          mov   = 1;
          mchan = s_in_chan;
          mcnt  = mcnt + 1;
        end else if (s_out_ready) begin
          mov = 0;
        end
        macc = nxt;
      end

      @(posedge clk); #1;
      chk($sformatf("r%0d out_valid", k), 64'(s_out_valid), 64'(mov));
      chk($sformatf("r%0d out_chan", k), 64'(s_out_chan), 64'(mchan));
      chk($sformatf("r%0d out_data", k), 64'(s_out_data), 64'(mdata));
      chk($sformatf("r%0d out_ovf", k), 64'(s_out_ovf), 64'(movf));
      chk($sformatf("r%0d accept_count", k), 64'(s_accept_count), 64'(mcnt));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
